// File: rtl/kros_pkg.sv
// Shared types and defaults for the LED pattern sequencer.
package kros_pkg;

   localparam int SEQ_W_DEF  = 6;
   localparam int STEP_W_DEF = 4;
   localparam int DATA_W_DEF = 10;

   localparam int HDR_LEN_LSB = 0;
   localparam int HDR_LEN_W   = 4;

   typedef enum logic [1:0] {
      FETCH_HDR,
      FETCH_STEP,
      RUN,
      EMPTY
   } state_e;

endpackage

// File: rtl/pattern_ctrl.sv
// Sequences LED pattern words out of the pattern ROM: header fetch, then one
// step word per throttle tick, with pushbutton selection of the sequence.
module pattern_ctrl
   import kros_pkg::*;
#(
   parameter int SEQ_W   = SEQ_W_DEF,
   parameter int STEP_W  = STEP_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ROM_LAT = 1
) (
   input  logic                      CLK_50,
   input  logic                      reset,
   input  logic                      pb_seq_up,
   input  logic                      pb_seq_dn,
   input  logic                      step_tick,
   input  logic [DATA_W-1:0]         rom_q,
   output logic [SEQ_W+STEP_W-1:0]   rom_addr,
   output logic [SEQ_W-1:0]          seq_num,
   output logic [DATA_W-1:0]         LEDR,
   output logic                      busy
);

   localparam int CNT_W = 2;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q,   cnt_d;
   logic [SEQ_W-1:0]       seq_q,   seq_d;
   logic [STEP_W-1:0]      step_q,  step_d;
   logic [HDR_LEN_W-1:0]   len_q,   len_d;
   logic [DATA_W-1:0]      led_q,   led_d;

   logic                   seq_chg;
   logic                   lat_done;
   logic [HDR_LEN_W-1:0]   hdr_len;

   // Up and down together cancel out and must not restart the fetch.
   assign seq_chg  = pb_seq_up ^ pb_seq_dn;
   assign lat_done = (cnt_q == CNT_W'(ROM_LAT));
   assign hdr_len  = rom_q[HDR_LEN_LSB +: HDR_LEN_W];

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block evaluation order.
   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) state_q <= FETCH_HDR;
      else       state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the block leaves a value unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      if (seq_chg) begin
         state_d = FETCH_HDR;
      end else begin
         unique case (state_q)
            FETCH_HDR:  if (lat_done) state_d = (hdr_len == '0) ? EMPTY : FETCH_STEP;
            FETCH_STEP: if (lat_done) state_d = RUN;
            RUN:        if (step_tick) state_d = FETCH_STEP;
            EMPTY:      state_d = EMPTY;
            default:    state_d = FETCH_HDR;
         endcase
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      seq_d  = seq_q;
      step_d = step_q;
      len_d  = len_q;
      led_d  = led_q;
      if (seq_chg) begin
         seq_d  = pb_seq_up ? seq_q + 1'b1 : seq_q - 1'b1;
         step_d = '0;
         cnt_d  = '0;
      end else begin
         unique case (state_q)
            FETCH_HDR: begin
               if (lat_done) begin
                  len_d = hdr_len;
                  cnt_d = '0;
                  if (hdr_len == '0) led_d  = '0;
                  else               step_d = STEP_W'(1);
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            FETCH_STEP: begin
               if (lat_done) begin
                  led_d = rom_q;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (step_tick)
                  step_d = (step_q == STEP_W'(len_q)) ? STEP_W'(1) : step_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         seq_q  <= '0;
         step_q <= '0;
         len_q  <= '0;
         led_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         seq_q  <= seq_d;
         step_q <= step_d;
         len_q  <= len_d;
         led_q  <= led_d;
      end
   end

   always_comb begin
      busy = (state_q == FETCH_HDR) || (state_q == FETCH_STEP);
   end

   assign rom_addr = {seq_q, step_q};
   assign seq_num  = seq_q;
   assign LEDR     = led_q;

endmodule

// File: tb/tb_pattern_ctrl.sv
// Directed bench for pattern_ctrl: a timestamp-based reference model checked
// every cycle, plus hand-computed expectations at the key points.
module tb_pattern_ctrl;

   localparam int ROM_LAT = 1;
   localparam int P_HDR = 0, P_STEP = 1, P_RUN = 2, P_EMPTY = 3;

   logic        CLK_50 = 1'b0;
   logic        reset  = 1'b1;
   logic        pb_seq_up = 1'b0;
   logic        pb_seq_dn = 1'b0;
   logic        step_tick = 1'b0;
   logic [9:0]  rom_q = '0;
   logic [9:0]  rom_addr;
   logic [5:0]  seq_num;
   logic [9:0]  LEDR;
   logic        busy;

   logic [9:0]  mem [0:1023];

   int n_vec = 0;
   int n_err = 0;

   pattern_ctrl #(.ROM_LAT(ROM_LAT)) dut (
      .CLK_50    (CLK_50),
      .reset     (reset),
      .pb_seq_up (pb_seq_up),
      .pb_seq_dn (pb_seq_dn),
      .step_tick (step_tick),
      .rom_q     (rom_q),
      .rom_addr  (rom_addr),
      .seq_num   (seq_num),
      .LEDR      (LEDR),
      .busy      (busy)
   );

   always #5 CLK_50 = ~CLK_50;

   // Pattern ROM with one cycle of read latency.
   always @(posedge CLK_50) rom_q <= mem[rom_addr];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: tracks which fetch is outstanding and the cycle it completes.
   int m_seq, m_step, m_len, m_led, m_phase, m_done, n;
   bit armed = 1'b0;

   always @(posedge CLK_50) begin
      if (reset) begin
         m_seq = 0; m_step = 0; m_len = 0; m_led = 0;
         m_phase = P_HDR; m_done = ROM_LAT; n = 0; armed = 1'b1;
      end else begin
         if (pb_seq_up != pb_seq_dn) begin
            m_seq   = pb_seq_up ? (m_seq + 1) % 64 : (m_seq + 63) % 64;
            m_step  = 0;
            m_phase = P_HDR;
            m_done  = n + 1 + ROM_LAT;
         end else if (m_phase == P_HDR && n == m_done) begin
            m_len = int'(mem[m_seq * 16]) % 16;
            if (m_len == 0) begin
               m_phase = P_EMPTY;
               m_led   = 0;
            end else begin
               m_step  = 1;
               m_phase = P_STEP;
               m_done  = n + 1 + ROM_LAT;
            end
         end else if (m_phase == P_STEP && n == m_done) begin
            m_led   = int'(mem[m_seq * 16 + m_step]);
            m_phase = P_RUN;
         end else if (m_phase == P_RUN && step_tick) begin
            m_step  = m_step % m_len + 1;
            m_phase = P_STEP;
            m_done  = n + 1 + ROM_LAT;
         end
         n++;
      end
   end

   always @(negedge CLK_50) begin
      if (armed) begin
         if (reset) begin
            check("cmp_rom_addr", rom_addr, 0);
            check("cmp_seq_num",  seq_num,  0);
            check("cmp_ledr",     LEDR,     0);
            check("cmp_busy",     busy,     1);
         end else begin
            check("cmp_rom_addr", rom_addr, m_seq * 16 + m_step);
            check("cmp_seq_num",  seq_num,  m_seq);
            check("cmp_ledr",     LEDR,     m_led);
            check("cmp_busy",     busy,     (m_phase == P_HDR || m_phase == P_STEP) ? 1 : 0);
         end
      end
   end

   task automatic cyc_wait(input int k);
      repeat (k) @(negedge CLK_50);
   endtask

   // Holds the given inputs for one cycle, starting at the current negedge.
   task automatic pulse(input logic up, input logic dn, input logic tk);
      pb_seq_up = up; pb_seq_dn = dn; step_tick = tk;
      @(negedge CLK_50);
      pb_seq_up = 1'b0; pb_seq_dn = 1'b0; step_tick = 1'b0;
   endtask

   int exp_nib [4] = '{2, 3, 1, 2};
   int exp_led [4] = '{'h002, 'h004, 'h001, 'h002};

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 10'((i * 37 + 5) % 1024);
      mem[0]     = 10'h003; mem[1] = 10'h001; mem[2] = 10'h002; mem[3] = 10'h004;
      mem[16]    = 10'h002; mem[17] = 10'h111; mem[18] = 10'h122;
      mem[32]    = 10'h000;
      mem[10'h3F0] = 10'h00F;

      cyc_wait(3);
      reset = 1'b0;                                  // cycle 0
      #1 check("rst_addr_c0", rom_addr, 0);
      check("rst_busy_c0", busy, 1);
      cyc_wait(1);
      check("hdr_addr_c1", rom_addr, 0);
      cyc_wait(1);
      check("step_addr_c2", rom_addr, 1);
      cyc_wait(1);
      check("ledr_c3", LEDR, 0);
      check("busy_c3", busy, 1);
      cyc_wait(1);
      check("ledr_c4", LEDR, 'h001);
      check("busy_c4", busy, 0);

      for (int i = 0; i < 4; i++) begin
         pulse(1'b0, 1'b0, 1'b1);
         check("tick_addr_nib", rom_addr[3:0], exp_nib[i]);
         cyc_wait(2);
         check("tick_ledr", LEDR, exp_led[i]);
         cyc_wait(7);
      end

      pulse(1'b0, 1'b1, 1'b0);
      check("dn_wrap_seq", seq_num, 63);
      check("dn_wrap_addr", rom_addr, 'h3F0);
      cyc_wait(6);
      pulse(1'b1, 1'b0, 1'b0);
      check("up_wrap_seq", seq_num, 0);
      check("up_wrap_addr", rom_addr, 'h000);
      cyc_wait(5);
      check("up_wrap_ledr", LEDR, 'h001);
      pulse(1'b1, 1'b1, 1'b0);
      check("updn_seq", seq_num, 0);
      check("updn_busy", busy, 0);

      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0);
      check("abort_addr", rom_addr, 'h010);
      cyc_wait(1);
      check("abort_no_old_word", LEDR, 'h001);
      cyc_wait(3);
      check("abort_new_word", LEDR, 'h111);

      pulse(1'b1, 1'b0, 1'b0);
      check("empty_hdr_addr", rom_addr, 'h020);
      cyc_wait(2);
      check("empty_ledr", LEDR, 0);
      check("empty_busy", busy, 0);
      for (int i = 0; i < 5; i++) begin
         pulse(1'b0, 1'b0, 1'b1);
         cyc_wait(1);
         check("empty_tick_addr", rom_addr, 'h020);
      end

      pulse(1'b0, 1'b1, 1'b0);
      cyc_wait(6);
      check("seq1_ledr", LEDR, 'h111);
      step_tick = 1'b1;
      cyc_wait(1);
      check("busy_during_tick", busy, 1);
      cyc_wait(1);
      step_tick = 1'b0;
      check("tick_in_fetch_addr", rom_addr, 'h012);
      cyc_wait(1);
      check("tick_in_fetch_ledr", LEDR, 'h122);
      cyc_wait(4);
      check("tick_in_fetch_hold", rom_addr, 'h012);

      pulse(1'b1, 1'b0, 1'b1);
      check("tick_vs_seq_addr", rom_addr, 'h020);
      cyc_wait(3);
      pulse(1'b0, 1'b1, 1'b0);
      cyc_wait(6);
      check("pre_reset_addr", rom_addr, 'h011);

      @(posedge CLK_50);
      #2 reset = 1'b1;
      #1 check("async_rst_addr", rom_addr, 0);
      check("async_rst_seq", seq_num, 0);
      check("async_rst_ledr", LEDR, 0);
      check("async_rst_busy", busy, 1);
      cyc_wait(3);
      reset = 1'b0;
      cyc_wait(4);
      check("rerun_ledr_c4", LEDR, 'h001);
      cyc_wait(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
